// File: rtl/timer_ctrl_pkg.sv
// rtl/timer_ctrl_pkg.sv - state encoding shared by the countdown timer control and display decode
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // States in which the preset digits may be edited through loadneg.
  function automatic logic is_edit_state(state_t s);
    return (s == S_IDLE) || (s == S_PAUSE);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - count-tick prescaler, emits tick on the last clock of each TICK_DIV period
module timer_prescaler #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  always_comb begin
    presc_d = presc_q;
    if (restart) begin
      presc_d = '0;
    end else if (run) begin
      presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = run && (presc_q == LAST);

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - min:sec countdown control FSM driving the cascaded digit chain
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int TICK_DIV     = 100,
  parameter int ALARM_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       load,
  input  logic       zero,
  output logic       en,
  output logic       loadneg,
  output logic       clearneg,
  output logic       done,
  output logic       running,
  output logic [1:0] state
);

  localparam int AW = (ALARM_CYCLES > 0) ? $clog2(ALARM_CYCLES + 1) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] alarm_q, alarm_d;
  logic          en_q, en_d;
  logic          loadneg_q, loadneg_d;
  logic          clearneg_q, clearneg_d;
  logic          done_q, done_d;
  logic          running_q, running_d;
  logic          presc_run;
  logic          presc_restart;
  logic          tick;

  timer_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .run    (presc_run),
    .restart(presc_restart),
    .tick   (tick)
  );

  always_comb begin
    state_d       = state_q;
    alarm_d       = '0;
    en_d          = 1'b0;
    loadneg_d     = 1'b1;
    clearneg_d    = 1'b1;
    presc_run     = 1'b0;
    presc_restart = 1'b0;

    if (clear) begin
      state_d       = S_IDLE;
      clearneg_d    = 1'b0;
      presc_restart = 1'b1;
    end else begin
      if (is_edit_state(state_q)) begin
        loadneg_d = ~load;
      end
      unique case (state_q)
        S_IDLE: begin
          presc_restart = 1'b1;
          if (start && !zero) begin
            state_d = S_RUN;
          end
        end
        // Zero is checked before ticking so the chain never wraps past 00:00.
        S_RUN: begin
          if (zero) begin
            state_d = S_DONE;
          end else if (pause) begin
            state_d = S_PAUSE;
          end else begin
            presc_run = 1'b1;
            en_d      = tick;
          end
        end
        S_PAUSE: begin
          if (start) begin
            state_d = zero ? S_DONE : S_RUN;
          end
        end
        S_DONE: begin
          if (start || (alarm_q == ALARM_LAST)) begin
            state_d = S_IDLE;
          end else begin
            alarm_d = alarm_q + AW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    done_d    = (state_d == S_DONE);
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      alarm_q    <= '0;
      en_q       <= 1'b0;
      loadneg_q  <= 1'b1;
      clearneg_q <= 1'b0;
      done_q     <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alarm_q    <= alarm_d;
      en_q       <= en_d;
      loadneg_q  <= loadneg_d;
      clearneg_q <= clearneg_d;
      done_q     <= done_d;
      running_q  <= running_d;
    end
  end

  assign en       = en_q;
  assign loadneg  = loadneg_q;
  assign clearneg = clearneg_q;
  assign done     = done_q;
  assign running  = running_q;
  assign state    = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - self-checking bench for timer_ctrl with a single mod-10 digit chain model
module tb_timer_ctrl;

  localparam int TICK_DIV     = 4;
  localparam int ALARM_CYCLES = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic       zero;
  logic       en, loadneg, clearneg, done, running;
  logic [1:0] state;

  logic [3:0] load_data = 4'd3;
  logic [3:0] digit = 4'd7;

  int checks = 0;
  int failures = 0;

  timer_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .ALARM_CYCLES(ALARM_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pause   (pause),
    .clear   (clear),
    .load    (load),
    .zero    (zero),
    .en      (en),
    .loadneg (loadneg),
    .clearneg(clearneg),
    .done    (done),
    .running (running),
    .state   (state)
  );

  always #5 clk = ~clk;

  // Digit chain model: one mod-10 down-counter with its zero flag.
  always @(posedge clk) begin
    if (clearneg == 1'b0) digit <= 4'd0;
    else if (loadneg == 1'b0) digit <= load_data;
    else if (en == 1'b1) digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
  end
  assign zero = (digit == 4'd0);

  typedef struct {
    logic [4:0] in;
    logic [1:0] st;
    logic       en, ln, cn, dn, rn;
    logic [3:0] dig;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mv(logic [4:0] in, logic [1:0] st, logic e, logic ln, logic cn,
                              logic dn, logic rn, logic [3:0] dig);
    vec_t v;
    v.in = in; v.st = st; v.en = e; v.ln = ln; v.cn = cn; v.dn = dn; v.rn = rn; v.dig = dig;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic p, input logic c, input logic l);
    rst = r; start = s; pause = p; clear = c; load = l;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] st, input logic e,
                         input logic dn, input logic rn);
    chk({tag, "_state"}, state, st);
    chk({tag, "_en"}, en, e);
    chk({tag, "_done"}, done, dn);
    chk({tag, "_running"}, running, rn);
  endtask

  initial begin
    bit found;

    // in = {rst, start, pause, clear, load}; dig 4'hF means digit not checked
    vq.push_back(mv(5'b10000, 2'd0, 0, 1, 0, 0, 0, 4'hF));
    vq.push_back(mv(5'b10000, 2'd0, 0, 1, 0, 0, 0, 4'd0));
    vq.push_back(mv(5'b00000, 2'd0, 0, 1, 1, 0, 0, 4'd0));
    vq.push_back(mv(5'b00001, 2'd0, 0, 0, 1, 0, 0, 4'd0));
    vq.push_back(mv(5'b00000, 2'd0, 0, 1, 1, 0, 0, 4'd3));
    vq.push_back(mv(5'b01000, 2'd1, 0, 1, 1, 0, 1, 4'd3));
    vq.push_back(mv(5'b00000, 2'd1, 0, 1, 1, 0, 1, 4'd3));
    vq.push_back(mv(5'b00001, 2'd1, 0, 1, 1, 0, 1, 4'd3));
    vq.push_back(mv(5'b00000, 2'd1, 0, 1, 1, 0, 1, 4'd3));
    vq.push_back(mv(5'b00000, 2'd1, 1, 1, 1, 0, 1, 4'd3));
    vq.push_back(mv(5'b00000, 2'd1, 0, 1, 1, 0, 1, 4'd2));
    vq.push_back(mv(5'b00001, 2'd1, 0, 1, 1, 0, 1, 4'd2));
    vq.push_back(mv(5'b00000, 2'd1, 0, 1, 1, 0, 1, 4'd2));
    vq.push_back(mv(5'b00000, 2'd1, 1, 1, 1, 0, 1, 4'd2));
    vq.push_back(mv(5'b00000, 2'd1, 0, 1, 1, 0, 1, 4'd1));
    vq.push_back(mv(5'b00000, 2'd1, 0, 1, 1, 0, 1, 4'd1));
    vq.push_back(mv(5'b00000, 2'd1, 0, 1, 1, 0, 1, 4'd1));
    vq.push_back(mv(5'b00000, 2'd1, 1, 1, 1, 0, 1, 4'd1));
    vq.push_back(mv(5'b00000, 2'd1, 0, 1, 1, 0, 1, 4'd0));
    for (int k = 0; k < 5; k++) vq.push_back(mv(5'b00000, 2'd3, 0, 1, 1, 1, 0, 4'd0));
    vq.push_back(mv(5'b00000, 2'd0, 0, 1, 1, 0, 0, 4'd0));

    load_data = 4'd3;
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].in[4], vq[i].in[3], vq[i].in[2], vq[i].in[1], vq[i].in[0]);
      chk_out($sformatf("v%0d", i), vq[i].st, vq[i].en, vq[i].dn, vq[i].rn);
      chk($sformatf("v%0d_loadneg", i), loadneg, vq[i].ln);
      chk($sformatf("v%0d_clearneg", i), clearneg, vq[i].cn);
      if (vq[i].dig != 4'hF) chk($sformatf("v%0d_digit", i), digit, vq[i].dig);
    end

    // Pause mid-period at presc=2 for 10 cycles, then resume.
    load_data = 4'd5;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk_out("t3_entry", 2'd1, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 1, 0, 0);
      chk_out($sformatf("t3_pause%0d", k), 2'd2, 0, 0, 0);
    end
    chk("t3_digit_held", digit, 4'd5);
    step(0, 1, 0, 0, 0);
    chk_out("t3_resume", 2'd1, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("t3_r1_en", en, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("t3_r2_en", en, 1'b1);
    chk("t3_r2_digit", digit, 4'd5);
    step(0, 0, 0, 0, 0);
    chk("t3_r3_digit", digit, 4'd4);

    // Clear and pause together while running.
    step(0, 0, 1, 1, 0);
    chk_out("t4_clear", 2'd0, 0, 0, 0);
    chk("t4_clearneg", clearneg, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("t4_clearneg_rel", clearneg, 1'b1);
    chk("t4_digit", digit, 4'd0);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0, 0, 0);
      chk_out($sformatf("t4_after%0d", k), 2'd0, 0, 0, 0);
    end

    // Start with count already zero stays idle.
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 0, 0, 0);
      chk_out($sformatf("t5_zstart%0d", k), 2'd0, 0, 0, 0);
    end

    // Early acknowledge of the alarm on its second cycle.
    load_data = 4'd2;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step(0, 0, 0, 0, 0);
      if (state == 2'd3) found = 1'b1;
    end
    chk("t6_reach_done", found, 1'b1);
    chk("t6_done_first", done, 1'b1);
    step(0, 0, 0, 0, 0);
    chk_out("t6_alarm2", 2'd3, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    chk_out("t6_ack", 2'd0, 0, 0, 0);

    // Reset asserted in the middle of a run.
    load_data = 4'd7;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("t7_run", state, 2'd1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk_out("t7_rst", 2'd0, 0, 0, 0);
    chk("t7_rst_loadneg", loadneg, 1'b1);
    chk("t7_rst_clearneg", clearneg, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("t7_clearneg_rel", clearneg, 1'b1);
    chk("t7_digit", digit, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
